// File: rtl/bp_be_dcache_wbuf_drain_if.sv
// -----------------------------------------------------------------------------
// bp_be_dcache_wbuf_drain_if
// Bundle of signals between the dcache write-buffer head, the drain block and
// the dcache data memory banks.
//
// Signals (direction as seen by the drain block, modport slave):
//   v_i             in   write-buffer head entry valid
//   wbuf_entry_i    in   head entry, packed {paddr, way_id, data, mask}
//   yumi_o          out  pop the write-buffer head this cycle
//   bank_busy_i     in   per-bank read port claimed by a load this cycle
//   lce_busy_i      in   LCE owns the whole data memory this cycle
//   data_mem_v_o    out  one-hot bank write enable
//   data_mem_addr_o out  bank row (set index)
//   data_mem_data_o out  write data
//   data_mem_mask_o out  byte write mask
//   empty_o         out  nothing held and nothing offered
//   starve_o        out  held store blocked for stall_limit_p cycles or more
// The master modport is the environment side (write buffer + data memory).
// -----------------------------------------------------------------------------
interface bp_be_dcache_wbuf_drain_if #(
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 22,
  parameter int ways_p        = 8,
  parameter int sets_p        = 64
);

  localparam int way_id_width_lp = $clog2(ways_p);
  localparam int index_width_lp  = $clog2(sets_p);
  localparam int mask_width_lp   = data_width_p / 8;
  localparam int entry_width_lp  = paddr_width_p + way_id_width_lp
                                 + data_width_p + mask_width_lp;

  logic                      v_i;
  logic [entry_width_lp-1:0] wbuf_entry_i;
  logic                      yumi_o;
  logic [ways_p-1:0]         bank_busy_i;
  logic                      lce_busy_i;
  logic [ways_p-1:0]         data_mem_v_o;
  logic [index_width_lp-1:0] data_mem_addr_o;
  logic [data_width_p-1:0]   data_mem_data_o;
  logic [mask_width_lp-1:0]  data_mem_mask_o;
  logic                      empty_o;
  logic                      starve_o;

  modport slave (
    input  v_i,
    input  wbuf_entry_i,
    output yumi_o,
    input  bank_busy_i,
    input  lce_busy_i,
    output data_mem_v_o,
    output data_mem_addr_o,
    output data_mem_data_o,
    output data_mem_mask_o,
    output empty_o,
    output starve_o
  );

  modport master (
    output v_i,
    output wbuf_entry_i,
    input  yumi_o,
    output bank_busy_i,
    output lce_busy_i,
    input  data_mem_v_o,
    input  data_mem_addr_o,
    input  data_mem_data_o,
    input  data_mem_mask_o,
    input  empty_o,
    input  starve_o
  );

endinterface

// File: rtl/bp_be_dcache_wbuf_drain.sv
// -----------------------------------------------------------------------------
// bp_be_dcache_wbuf_drain
// Drains committed stores from the dcache write buffer into the banked data
// memory. One entry at a time is popped into a holding register and then
// written as a masked single-bank write. Banks are word-interleaved with the
// bank selected by word_offset XOR way_id. The write yields to LCE fills
// (all banks) and to load reads on the target bank. A registered starvation
// flag reports a held store blocked for stall_limit_p cycles.
//
// Ports:
//   clk_i    in  clock
//   reset_i  in  synchronous active-high reset; discards any held entry
//   bus      bp_be_dcache_wbuf_drain_if.slave (write-buffer handshake and
//            data-memory write port, see the interface header)
// -----------------------------------------------------------------------------
module bp_be_dcache_wbuf_drain #(
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 22,
  parameter int ways_p        = 8,
  parameter int sets_p        = 64,
  parameter int stall_limit_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  bp_be_dcache_wbuf_drain_if.slave     bus
);

  localparam int byte_off_width_lp = $clog2(data_width_p / 8);
  localparam int way_id_width_lp   = $clog2(ways_p);
  localparam int index_width_lp    = $clog2(sets_p);
  localparam int mask_width_lp     = data_width_p / 8;
  localparam int cnt_width_lp      = $clog2(stall_limit_p + 1);
  localparam int index_lsb_lp      = byte_off_width_lp + way_id_width_lp;
  localparam int tag_lsb_lp        = index_lsb_lp + index_width_lp;

  localparam logic [cnt_width_lp-1:0] stall_limit_lp = cnt_width_lp'(stall_limit_p);

  typedef struct packed {
    logic [paddr_width_p-1:0]   paddr;
    logic [way_id_width_lp-1:0] way_id;
    logic [data_width_p-1:0]    data;
    logic [mask_width_lp-1:0]   mask;
  } entry_s;

  typedef enum logic {
    e_idle = 1'b0,
    e_held = 1'b1
  } state_e;

  state_e                      state_r, state_n;
  entry_s                      hold_r;
  entry_s                      entry_in_s;
  logic                        pend_v_s;
  logic                        fire_s;
  logic                        yumi_s;
  logic [ways_p-1:0]           data_mem_v_s;
  logic [ways_p-1:0]           bank_onehot_s;
  logic [way_id_width_lp-1:0]  hold_word_off_s;
  logic [way_id_width_lp-1:0]  hold_bank_s;
  logic [index_width_lp-1:0]   hold_index_s;
  logic [cnt_width_lp-1:0]     cnt_r, cnt_n;
  logic                        starve_r;
  logic                        unused_s;

  assign entry_in_s = entry_s'(bus.wbuf_entry_i);
  assign pend_v_s   = (state_r == e_held);

  // Address decode of the held entry: word offset, set index and target bank.
  assign hold_word_off_s = hold_r.paddr[byte_off_width_lp +: way_id_width_lp];
  assign hold_index_s    = hold_r.paddr[index_lsb_lp +: index_width_lp];
  assign hold_bank_s     = hold_word_off_s ^ hold_r.way_id;
  assign bank_onehot_s   = {{(ways_p-1){1'b0}}, 1'b1} << hold_bank_s;

  // Byte-offset and tag bits of the held address play no part in the write.
  assign unused_s = ^{hold_r.paddr[paddr_width_p-1:tag_lsb_lp],
                      hold_r.paddr[byte_off_width_lp-1:0]};

  // State register: IDLE/HELD, i.e. the pend_v flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic: a pop always (re)fills the holder; a write alone empties it.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: begin
        if (yumi_s) begin
          state_n = e_held;
        end else begin
          state_n = e_idle;
        end
      end
      e_held: begin
        if (yumi_s) begin
          state_n = e_held;
        end else if (fire_s) begin
          state_n = e_idle;
        end else begin
          state_n = e_held;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // Output logic: write issue, pop handshake and bank enable.
  // Reset gates both so nothing moves in the reset cycle even if an entry was held.
  always_comb begin
    fire_s       = 1'b0;
    yumi_s       = 1'b0;
    data_mem_v_s = {ways_p{1'b0}};
    case (state_r)
      e_held: begin
        fire_s = ~reset_i & ~bus.lce_busy_i & ~bus.bank_busy_i[hold_bank_s];
        yumi_s = ~reset_i & bus.v_i & fire_s;
      end
      e_idle: begin
        fire_s = 1'b0;
        yumi_s = ~reset_i & bus.v_i;
      end
      default: begin
        fire_s = 1'b0;
        yumi_s = 1'b0;
      end
    endcase
    if (fire_s) begin
      data_mem_v_s = bank_onehot_s;
    end else begin
      data_mem_v_s = {ways_p{1'b0}};
    end
  end

  // Holding register: captures the head entry on every pop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_r <= '0;
    end else if (yumi_s) begin
      hold_r <= entry_in_s;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Blocked-cycle counter: saturating, cleared on write or when nothing is held.
  always_comb begin
    cnt_n = cnt_r;
    if (~pend_v_s | fire_s) begin
      cnt_n = {cnt_width_lp{1'b0}};
    end else if (cnt_r == stall_limit_lp) begin
      cnt_n = cnt_r;
    end else begin
      cnt_n = cnt_r + cnt_width_lp'(1);
    end
  end

  // Counter and starvation flag registers; the flag tracks counter == limit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r    <= {cnt_width_lp{1'b0}};
      starve_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_n;
      starve_r <= (cnt_n == stall_limit_lp);
    end
  end

  assign bus.yumi_o          = yumi_s;
  assign bus.data_mem_v_o    = data_mem_v_s;
  assign bus.data_mem_addr_o = hold_index_s;
  assign bus.data_mem_data_o = hold_r.data;
  assign bus.data_mem_mask_o = hold_r.mask;
  assign bus.empty_o         = ~pend_v_s & ~bus.v_i;
  assign bus.starve_o        = starve_r;

endmodule

// File: tb/tb_bp_be_dcache_wbuf_drain.sv
// -----------------------------------------------------------------------------
// tb_bp_be_dcache_wbuf_drain
// Self-checking bench: directed scenarios followed by random traffic, every
// cycle compared against a transaction-level reference model of the drain.
// -----------------------------------------------------------------------------
module tb_bp_be_dcache_wbuf_drain;

  localparam int DW  = 64;
  localparam int PW  = 22;
  localparam int WAYS = 8;
  localparam int SETS = 64;
  localparam int LIM = 16;
  localparam int EW  = PW + 3 + DW + DW/8;

  logic clk;
  logic reset;

  bp_be_dcache_wbuf_drain_if #(
    .data_width_p(DW), .paddr_width_p(PW), .ways_p(WAYS), .sets_p(SETS)
  ) bus_if ();

  bp_be_dcache_wbuf_drain #(
    .data_width_p(DW), .paddr_width_p(PW), .ways_p(WAYS), .sets_p(SETS),
    .stall_limit_p(LIM)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit            held;
  logic [EW-1:0] held_e;
  int            blk;
  bit            last_exp_yumi;
  logic [EW-1:0] src_q[$];

  // last observed DUT outputs (for directed checks)
  logic       obs_yumi, obs_empty, obs_starve;
  logic [7:0] obs_dv, obs_mask;
  logic [5:0] obs_addr;
  logic [63:0] obs_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int unsigned paddr, input int unsigned way,
                                       input logic [63:0] data, input logic [7:0] mask);
    logic [PW-1:0] p;
    logic [2:0]    w;
    p = PW'(paddr);
    w = 3'(way);
    return {p, w, data, mask};
  endfunction

  function automatic int unsigned f_paddr(input logic [EW-1:0] e);
    return int'(e[EW-1 -: PW]);
  endfunction
  function automatic int unsigned f_way(input logic [EW-1:0] e);
    return int'(e[EW-PW-1 -: 3]);
  endfunction
  function automatic int unsigned f_bank(input logic [EW-1:0] e);
    return ((f_paddr(e) / 8) % WAYS) ^ f_way(e);
  endfunction
  function automatic int unsigned f_index(input logic [EW-1:0] e);
    return (f_paddr(e) / (8 * WAYS)) % SETS;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input bit v, input logic [EW-1:0] e, input logic [7:0] busy,
                      input bit lce, input bit rst);
    bit         exp_fire, exp_yumi, held_old;
    logic [7:0] exp_dv;
    @(negedge clk);
    reset              = rst;
    bus_if.v_i         = v;
    bus_if.wbuf_entry_i = e;
    bus_if.bank_busy_i = busy;
    bus_if.lce_busy_i  = lce;
    #1;
    exp_fire = !rst && held && !lce && !busy[f_bank(held_e)];
    exp_dv   = exp_fire ? (8'h01 << f_bank(held_e)) : 8'h00;
    exp_yumi = !rst && v && (!held || exp_fire);
    chk("yumi",   bus_if.yumi_o,       exp_yumi);
    chk("dmem_v", bus_if.data_mem_v_o, exp_dv);
    chk("empty",  bus_if.empty_o,      !held && !v);
    chk("starve", bus_if.starve_o,     blk == LIM);
    if (exp_fire) begin
      chk("addr", bus_if.data_mem_addr_o, f_index(held_e));
      chk("data", bus_if.data_mem_data_o, held_e[71:8]);
      chk("mask", bus_if.data_mem_mask_o, held_e[7:0]);
    end
    obs_yumi   = bus_if.yumi_o;
    obs_empty  = bus_if.empty_o;
    obs_starve = bus_if.starve_o;
    obs_dv     = bus_if.data_mem_v_o;
    obs_mask   = bus_if.data_mem_mask_o;
    obs_addr   = bus_if.data_mem_addr_o;
    obs_data   = bus_if.data_mem_data_o;
    last_exp_yumi = exp_yumi;
    @(posedge clk);
    held_old = held;
    if (rst) begin
      held = 1'b0;
      blk  = 0;
    end else begin
      if (!held_old || exp_fire) blk = 0;
      else if (blk < LIM) blk++;
      if (exp_yumi) begin
        held   = 1'b1;
        held_e = e;
      end else if (exp_fire) begin
        held = 1'b0;
      end
    end
  endtask

  logic [EW-1:0] e1, ea, eb, ec, ez, en, junk;

  initial begin
    reset = 1'b1;
    bus_if.v_i = 1'b0;
    bus_if.wbuf_entry_i = '0;
    bus_if.bank_busy_i = 8'h00;
    bus_if.lce_busy_i = 1'b0;
    held = 1'b0;
    held_e = '0;
    blk = 0;
    repeat (2) @(posedge clk);

    e1 = mk(32'h1048, 3, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    ea = mk(32'h0000, 0, 64'h1111, 8'h0F);
    eb = mk(32'h0028, 0, 64'h2222, 8'hF0);
    ec = mk(32'h0038, 0, 64'h3333, 8'h3C);

    // reset state
    step(1'b0, '0, 8'h00, 1'b0, 1'b1);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("rst_empty", obs_empty, 1'b1);
    chk("rst_dv", obs_dv, 8'h00);

    // single store
    step(1'b1, e1, 8'h00, 1'b0, 1'b0);
    chk("t1_yumi", obs_yumi, 1'b1);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t1_dv", obs_dv, 8'h04);
    chk("t1_addr", obs_addr, 6'h01);
    chk("t1_data", obs_data, 64'hDEADBEEF_CAFEF00D);
    chk("t1_mask", obs_mask, 8'hFF);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t1_empty", obs_empty, 1'b1);

    // back-to-back stores to banks 0/5/7
    step(1'b1, ea, 8'h00, 1'b0, 1'b0);
    chk("t2_y0", obs_yumi, 1'b1);
    step(1'b1, eb, 8'h00, 1'b0, 1'b0);
    chk("t2_y1", obs_yumi, 1'b1);
    chk("t2_dv1", obs_dv, 8'h01);
    step(1'b1, ec, 8'h00, 1'b0, 1'b0);
    chk("t2_y2", obs_yumi, 1'b1);
    chk("t2_dv2", obs_dv, 8'h20);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t2_dv3", obs_dv, 8'h80);

    // bank conflict on bank 2
    step(1'b1, e1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ea, 8'h04, 1'b0, 1'b0);
      chk("t3_dv_blk", obs_dv, 8'h00);
      chk("t3_yumi_blk", obs_yumi, 1'b0);
    end
    step(1'b1, ea, 8'h00, 1'b0, 1'b0);
    chk("t3_dv_go", obs_dv, 8'h04);
    chk("t3_yumi_go", obs_yumi, 1'b1);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);

    // LCE priority and starvation
    step(1'b1, ea, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 8'h00, 1'b1, 1'b0);
      chk("t4_dv", obs_dv, 8'h00);
      if (i == 15) chk("t4_starve15", obs_starve, 1'b0);
      if (i == 16) chk("t4_starve16", obs_starve, 1'b1);
    end
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t4_fire", obs_dv, 8'h01);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t4_starve_drop", obs_starve, 1'b0);

    // reset mid-operation
    step(1'b1, e1, 8'h00, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 8'h00, 1'b1, 1'b0);
    step(1'b0, '0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 8'h00, 1'b0, 1'b0);
      chk("t5_dv", obs_dv, 8'h00);
      chk("t5_empty", obs_empty, 1'b1);
      chk("t5_starve", obs_starve, 1'b0);
    end

    // zero mask followed by a normal entry
    ez = mk(32'h0010, 1, 64'h5555, 8'h00);
    en = mk(32'h0018, 1, 64'h6666, 8'hAA);
    step(1'b1, ez, 8'h00, 1'b0, 1'b0);
    step(1'b1, en, 8'h00, 1'b0, 1'b0);
    chk("t6_dv", obs_dv, 8'h08);
    chk("t6_mask", obs_mask, 8'h00);
    step(1'b0, '0, 8'h00, 1'b0, 1'b0);
    chk("t6_next", obs_dv, 8'h04);
    chk("t6_next_mask", obs_mask, 8'hAA);

    // random traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit         v, lce, rst;
      logic [7:0] busy;
      logic [7:0] m;
      if (src_q.size() < 4 && ($urandom_range(0, 2) == 0)) begin
        m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        src_q.push_back(mk($urandom, $urandom, {$urandom, $urandom}, m));
      end
      v    = (src_q.size() != 0) && ($urandom_range(0, 3) != 0);
      lce  = ($urandom_range(0, 7) == 0);
      busy = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 99) < 3) busy = 8'hFF;
      if ($urandom_range(0, 99) < 2) lce = 1'b1;
      rst  = ($urandom_range(0, 299) == 0);
      junk = mk($urandom, $urandom, {$urandom, $urandom}, 8'($urandom));
      step(v, v ? src_q[0] : junk, busy, lce, rst);
      if (rst) src_q.delete();
      else if (v && last_exp_yumi) void'(src_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_wbuf_drain.md
Name: bp_be_dcache_wbuf_drain

Overview:
- Downstream consumer of the dcache write buffer.
- Pops one committed store entry (paddr, way_id, data, mask) at a time into a single holding register.
- Commits the held entry as a masked single-bank write to the data memory. Banks are word-interleaved: bank = word_offset XOR way_id.
- Yields to LCE fills and same-cycle load reads. Raises a starvation flag when a held store is blocked too long.

Parameters:
- data_width_p, 64, word width in bits. Each data bank is this wide.
- paddr_width_p, 22, physical address width.
- ways_p, 8, associativity. Also the number of data banks and the words per block.
- sets_p, 64, number of sets. Also the depth of each bank.
- stall_limit_p, 16, blocked cycles before starve_o asserts. Must be ≥1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  wbuf head entry valid
- wbuf_entry_i  in  `bp_be_dcache_wbuf_entry_width(paddr_width_p,data_width_p,ways_p)  head entry (bp_be_dcache_wbuf_entry_s)
- yumi_o  out  1  pop wbuf head this cycle
- bank_busy_i  in  ways_p  per-bank read port claimed by a load this cycle
- lce_busy_i  in  1  LCE owns data memory this cycle (all banks)
- data_mem_v_o  out  ways_p  one-hot bank write enable
- data_mem_addr_o  out  log2(sets_p)  bank row (set index)
- data_mem_data_o  out  data_width_p  write data
- data_mem_mask_o  out  data_width_p/8  byte write mask
- empty_o  out  1  holding register empty and v_i low
- starve_o  out  1  held store blocked ≥ stall_limit_p cycles

Behaviour:
- Address fields:
  - byte_off = log2(data_width_p/8) bits.
  - word_off = paddr[byte_off+log2(ways_p)-1 : byte_off].
  - index = next log2(sets_p) bits above word_off.
  - bank = word_off ^ way_id, width log2(ways_p).
- Two states, tracked by the register pend_v:
  - IDLE (pend_v=0)
  - HELD (pend_v=1): hold_r holds one entry.
- fire = pend_v & ~lce_busy_i & ~bank_busy_i[hold bank].
- data_mem_v_o = fire ? (1 << hold bank) : 0.
- data_mem_addr_o, data_mem_data_o and data_mem_mask_o are driven combinationally from hold_r. They are don't-care when data_mem_v_o is 0.
- yumi_o = v_i & (~pend_v | fire). This is a single-cycle pop with no bubble on back-to-back stores.
- Next-state:
  - If yumi_o: load hold_r and set pend_v=1.
  - Else if fire: pend_v=0.
  - Otherwise hold.
- Write latency: an entry popped in cycle N writes no earlier than cycle N+1.
- Mask all-zero entries still occupy one write slot and assert data_mem_v_o; nothing is dropped.
- Ordering is strictly FIFO. At most one bank is written per cycle.
- Starvation counter:
  - Counts cycles with pend_v & ~fire and saturates at stall_limit_p.
  - Clears to 0 on fire or when pend_v=0.
  - starve_o is registered: 1 while counter == stall_limit_p.
  - starve_o drops the cycle after fire.
- empty_o = ~pend_v & ~v_i (combinational).
- Reset, including mid-operation: pend_v=0, counter=0, starve_o=0, yumi_o=0 during the reset cycle, data_mem_v_o=0. A held entry is discarded; the upstream wbuf is reset in the same cycle.
- Simultaneous events:
  - fire and a new pop in the same cycle: hold_r is replaced and pend_v stays 1.
  - lce_busy_i has priority over everything; no write occurs while it is high.

Test Plan:
1. Single store, no conflicts. Reset, then v_i=1 with paddr=0x1048, way_id=3, data=0xDEADBEEF_CAFEF00D, mask=0xFF.
   -> yumi_o=1 at cycle 0. At cycle 1: data_mem_v_o=0x04 (bank 2), addr=0x01, data=0xDEADBEEF_CAFEF00D, mask=0xFF. empty_o=1 at cycle 2.
2. Back-to-back stores. Three entries, banks 0/5/7, no conflicts.
   -> yumi_o high 3 consecutive cycles. data_mem_v_o goes 0x01, 0x20, 0x80 on cycles 1–3, in order.
3. Bank conflict. Entry held for bank 2 and bank_busy_i=0x04 for 4 cycles.
   -> data_mem_v_o=0 and yumi_o=0 throughout, even with v_i=1. The write issues on the first cycle bank_busy_i[2]=0, with yumi_o=1 that same cycle.
4. LCE priority and starvation. stall_limit_p=16, held entry, lce_busy_i=1 for 20 cycles.
   -> No write. starve_o rises after exactly 16 blocked cycles. The write fires when lce_busy_i drops, and starve_o=0 the next cycle.
5. Reset mid-operation. Held entry blocked, assert reset_i for 1 cycle, release with v_i=0.
   -> data_mem_v_o stays 0 forever, empty_o=1, starve_o=0.
6. Zero mask. Entry with mask=0x00.
   -> data_mem_v_o asserts for one cycle with mask=0x00, and the next entry follows normally.
